// File: rtl/apb_sram_slave.sv
// APB4 slave scratch RAM with byte-lane strobes, configurable wait states and
// slave-error responses for misaligned or out-of-range accesses.
module apb_sram_slave #(
    parameter int ADDR_WIDTH  = 8,
    parameter int DATA_WIDTH  = 32,
    parameter int DEPTH       = 64,
    parameter int WAIT_STATES = 0
) (
    input  logic                    PCLK,
    input  logic                    PRESET,
    input  logic                    psel,
    input  logic                    penable,
    input  logic                    pwrite,
    input  logic [ADDR_WIDTH-1:0]   paddr,
    input  logic [DATA_WIDTH-1:0]   pwdata,
    input  logic [DATA_WIDTH/8-1:0] pstrb,
    output logic [DATA_WIDTH-1:0]   prdata,
    output logic                    pready,
    output logic                    pslverr
);

    localparam int BYTES = DATA_WIDTH / 8;
    localparam int AL    = $clog2(BYTES);
    localparam int WW    = ADDR_WIDTH - AL;
    localparam int IW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    localparam logic [WW:0]           DEPTH_W    = (WW + 1)'(DEPTH);
    localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK = ADDR_WIDTH'(BYTES - 1);
    localparam logic [7:0]            WS         = 8'(WAIT_STATES);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_ACCESS = 2'd1;
    localparam logic [1:0] ST_DONE   = 2'd2;

    logic [1:0]            state;
    logic [7:0]            wait_cnt;
    logic [WW-1:0]         lat_idx;
    logic                  lat_write;
    logic                  lat_err;
    logic [DATA_WIDTH-1:0] lat_wdata;
    logic [BYTES-1:0]      lat_strb;

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    logic [ADDR_WIDTH-1:0] req_shift;
    logic [WW-1:0]         req_idx;
    logic                  req_err;
    logic                  setup;
    logic                  at_last;
    logic                  commit;
    logic                  load_now;
    logic [WW-1:0]         load_idx;
    logic                  load_err;
    logic                  load_write;

    always_comb begin
        req_shift = paddr >> AL;
        req_idx   = req_shift[WW-1:0];
        req_err   = ((paddr & ALIGN_MASK) != '0) || ({1'b0, req_idx} >= DEPTH_W);

        // DONE behaves exactly like IDLE so a new setup is accepted right after completion.
        setup     = psel && !penable && (state != ST_ACCESS);
        at_last   = (state == ST_ACCESS) && (wait_cnt == WS);
        commit    = at_last && psel && penable && lat_write && !lat_err && !PRESET;

        // Response registers load on the edge that brings the counter to WAIT_STATES.
        load_now  = (setup && (WS == 8'd0)) ||
                    ((state == ST_ACCESS) && psel && (wait_cnt == WS - 8'd1));

        load_idx   = (state == ST_ACCESS) ? lat_idx   : req_idx;
        load_err   = (state == ST_ACCESS) ? lat_err   : req_err;
        load_write = (state == ST_ACCESS) ? lat_write : pwrite;
    end

    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            state     <= ST_IDLE;
            wait_cnt  <= '0;
            lat_idx   <= '0;
            lat_write <= 1'b0;
            lat_err   <= 1'b0;
            lat_wdata <= '0;
            lat_strb  <= '0;
            pready    <= 1'b0;
            pslverr   <= 1'b0;
            prdata    <= '0;
        end else begin
            pready  <= 1'b0;
            pslverr <= 1'b0;
            prdata  <= '0;
            if (load_now) begin
                pready  <= 1'b1;
                pslverr <= load_err;
                prdata  <= (!load_err && !load_write) ? mem[load_idx[IW-1:0]] : '0;
            end

            case (state)
                ST_IDLE, ST_DONE: begin
                    if (setup) begin
                        lat_idx   <= req_idx;
                        lat_write <= pwrite;
                        lat_err   <= req_err;
                        lat_wdata <= pwdata;
                        lat_strb  <= pstrb;
                        wait_cnt  <= '0;
                        state     <= ST_ACCESS;
                    end else begin
                        state <= ST_IDLE;
                    end
                end
                ST_ACCESS: begin
                    if (!psel) begin
                        state <= ST_IDLE;
                    end else if (wait_cnt != WS) begin
                        wait_cnt <= wait_cnt + 8'd1;
                    end else if (penable) begin
                        state <= ST_DONE;
                    end else begin
                        // Master stalled the enable phase: keep the response presented.
                        pready  <= pready;
                        pslverr <= pslverr;
                        prdata  <= prdata;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    // NOTE: the RAM array has no reset branch; clearing it would need a
    // per-word reset network and its contents are defined as unknown anyway.
    always_ff @(posedge PCLK) begin
        if (commit) begin
            for (int b = 0; b < BYTES; b++) begin
                if (lat_strb[b]) begin
                    mem[lat_idx[IW-1:0]][b*8 +: 8] <= lat_wdata[b*8 +: 8];
                end
            end
        end
    end

endmodule

// File: tb/tb_apb_sram_slave.sv
// Scoreboard bench for apb_sram_slave: three instances cover the default
// configuration, wait states with a 9-bit address, and a 64-bit data path.
module tb_apb_sram_slave;

    logic        PCLK = 1'b0;
    logic        PRESET;
    logic        psel_a, psel_b, psel_c;
    logic        penable, pwrite;
    logic [8:0]  paddr;
    logic [63:0] pwdata;
    logic [7:0]  pstrb;

    logic [31:0] prdata_a, prdata_b;
    logic [63:0] prdata_c;
    logic        pready_a, pready_b, pready_c;
    logic        pslverr_a, pslverr_b, pslverr_c;

    always #5 PCLK = ~PCLK;

    apb_sram_slave #(.ADDR_WIDTH(8), .DATA_WIDTH(32), .DEPTH(64), .WAIT_STATES(0)) u_a (
        .PCLK(PCLK), .PRESET(PRESET), .psel(psel_a), .penable(penable), .pwrite(pwrite),
        .paddr(paddr[7:0]), .pwdata(pwdata[31:0]), .pstrb(pstrb[3:0]),
        .prdata(prdata_a), .pready(pready_a), .pslverr(pslverr_a)
    );

    apb_sram_slave #(.ADDR_WIDTH(9), .DATA_WIDTH(32), .DEPTH(64), .WAIT_STATES(3)) u_b (
        .PCLK(PCLK), .PRESET(PRESET), .psel(psel_b), .penable(penable), .pwrite(pwrite),
        .paddr(paddr), .pwdata(pwdata[31:0]), .pstrb(pstrb[3:0]),
        .prdata(prdata_b), .pready(pready_b), .pslverr(pslverr_b)
    );

    apb_sram_slave #(.ADDR_WIDTH(9), .DATA_WIDTH(64), .DEPTH(64), .WAIT_STATES(0)) u_c (
        .PCLK(PCLK), .PRESET(PRESET), .psel(psel_c), .penable(penable), .pwrite(pwrite),
        .paddr(paddr), .pwdata(pwdata), .pstrb(pstrb),
        .prdata(prdata_c), .pready(pready_c), .pslverr(pslverr_c)
    );

    logic [2:0]  rdy_v;
    logic [2:0]  err_v;
    logic [63:0] rd_v [3];

    assign rdy_v   = {pready_c, pready_b, pready_a};
    assign err_v   = {pslverr_c, pslverr_b, pslverr_a};
    assign rd_v[0] = {32'h0, prdata_a};
    assign rd_v[1] = {32'h0, prdata_b};
    assign rd_v[2] = prdata_c;

    typedef struct {
        int          id;
        bit          is_read;
        logic [63:0] rdata;
        bit          err;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, req, $time);
        end
    endtask

    // Monitor: every pready pulse must match the oldest outstanding expectation.
    always @(negedge PCLK) begin
        if (!PRESET) begin
            for (int id = 0; id < 3; id++) begin
                if (rdy_v[id]) begin
                    if (exp_q.size() == 0) begin
                        check($sformatf("unexpected_pready_dut%0d", id), 64'd1, 64'd0);
                    end else begin
                        mon_e = exp_q.pop_front();
                        check("resp_dut_id", 64'(id), 64'(mon_e.id));
                        check("resp_pslverr", {63'd0, err_v[id]}, {63'd0, mon_e.err});
                        if (mon_e.is_read || mon_e.err)
                            check("resp_prdata", rd_v[id], mon_e.rdata);
                    end
                end else if (err_v[id] || (rd_v[id] != 64'd0)) begin
                    check($sformatf("outputs_zero_without_pready_dut%0d", id), 64'd1, 64'd0);
                end
            end
        end
    end

    task automatic select(input int id);
        psel_a = (id == 0);
        psel_b = (id == 1);
        psel_c = (id == 2);
    endtask

    // One complete transfer; leaves psel high so another call runs back-to-back.
    task automatic xfer(input int id, input bit wr, input logic [8:0] addr,
                        input logic [63:0] wdata, input logic [7:0] strb,
                        input logic [63:0] exp_rdata, input bit exp_err, input int exp_wait);
        int   cycles;
        exp_t e;
        select(id);
        penable = 1'b0;
        pwrite  = wr;
        paddr   = addr;
        pwdata  = wdata;
        pstrb   = strb;
        e.id = id; e.is_read = !wr; e.rdata = exp_rdata; e.err = exp_err;
        exp_q.push_back(e);
        @(posedge PCLK); #1;
        penable = 1'b1;
        cycles  = 0;
        while (!rdy_v[id] && cycles < 50) begin
            @(posedge PCLK); #1;
            cycles++;
        end
        check($sformatf("wait_cycles_dut%0d_addr%0h", id, addr), 64'(cycles), 64'(exp_wait));
        @(posedge PCLK); #1;
    endtask

    task automatic idle(input int n);
        select(-1);
        penable = 1'b0;
        repeat (n) begin
            @(posedge PCLK); #1;
        end
    endtask

    logic [63:0] c_data [8];

    initial begin
        c_data[0] = 64'h0123_4567_89AB_CDEF;
        c_data[1] = 64'hFEDC_BA98_7654_3210;
        c_data[2] = 64'hDEAD_BEEF_CAFE_F00D;
        c_data[3] = 64'h0000_0000_0000_0001;
        c_data[4] = 64'h8000_0000_0000_0000;
        c_data[5] = 64'hA5A5_A5A5_5A5A_5A5A;
        c_data[6] = 64'hFFFF_FFFF_FFFF_FFFF;
        c_data[7] = 64'h1357_9BDF_0246_8ACE;

        PRESET = 1'b1;
        select(-1);
        penable = 1'b0;
        pwrite  = 1'b0;
        paddr   = '0;
        pwdata  = '0;
        pstrb   = '0;
        repeat (2) @(posedge PCLK);
        #1;
        PRESET = 1'b0;
        check("reset_pready_a", {63'd0, pready_a}, 64'd0);
        check("reset_pslverr_b", {63'd0, pslverr_b}, 64'd0);
        check("reset_prdata_c", prdata_c, 64'd0);
        idle(1);

        // Basic write then immediate read-after-write.
        xfer(0, 1, 9'h010, 64'hDEADBEEF, 8'hF, 64'd0, 0, 0);
        xfer(0, 0, 9'h010, 64'd0, 8'hF, 64'hDEADBEEF, 0, 0);
        idle(1);

        // Reset held two cycles while a write to 0x10 is attempted.
        PRESET  = 1'b1;
        select(0);
        pwrite  = 1'b1;
        paddr   = 9'h010;
        pwdata  = 64'h12345678;
        pstrb   = 8'hF;
        penable = 1'b0;
        @(posedge PCLK); #1;
        penable = 1'b1;
        @(posedge PCLK); #1;
        check("reset_hold_pready_a", {63'd0, pready_a}, 64'd0);
        check("reset_hold_pslverr_a", {63'd0, pslverr_a}, 64'd0);
        check("reset_hold_prdata_a", {32'd0, prdata_a}, 64'd0);
        select(-1);
        penable = 1'b0;
        PRESET  = 1'b0;
        idle(1);
        xfer(0, 0, 9'h010, 64'd0, 8'h0, 64'hDEADBEEF, 0, 0);

        // Byte strobes, including an all-zero strobe no-op.
        xfer(0, 1, 9'h020, 64'h11223344, 8'hF, 64'd0, 0, 0);
        xfer(0, 1, 9'h020, 64'hAABBCCDD, 8'h5, 64'd0, 0, 0);
        xfer(0, 1, 9'h020, 64'h00000000, 8'h0, 64'd0, 0, 0);
        xfer(0, 0, 9'h020, 64'd0, 8'h0, 64'h11BB33DD, 0, 0);

        // Misaligned accesses error and leave RAM untouched; last word is legal.
        xfer(0, 1, 9'h013, 64'hFFFFFFFF, 8'hF, 64'd0, 1, 0);
        xfer(0, 0, 9'h012, 64'd0, 8'h0, 64'd0, 1, 0);
        xfer(0, 0, 9'h010, 64'd0, 8'h0, 64'hDEADBEEF, 0, 0);
        xfer(0, 1, 9'h0FC, 64'h0F0F0F0F, 8'hF, 64'd0, 0, 0);
        xfer(0, 0, 9'h0FC, 64'd0, 8'h0, 64'h0F0F0F0F, 0, 0);

        // Wait states and out-of-range index on the 9-bit-address instance.
        xfer(1, 1, 9'h040, 64'hCAFEF00D, 8'hF, 64'd0, 0, 3);
        xfer(1, 0, 9'h040, 64'd0, 8'h0, 64'hCAFEF00D, 0, 3);
        xfer(1, 0, 9'h100, 64'd0, 8'h0, 64'd0, 1, 3);
        xfer(1, 1, 9'h1FC, 64'h77777777, 8'hF, 64'd0, 1, 3);
        xfer(1, 1, 9'h044, 64'h01020304, 8'hF, 64'd0, 0, 3);
        idle(1);

        // Abort: psel dropped during the second wait cycle of a write.
        select(1);
        pwrite  = 1'b1;
        paddr   = 9'h044;
        pwdata  = 64'h55555555;
        pstrb   = 8'hF;
        penable = 1'b0;
        @(posedge PCLK); #1;
        penable = 1'b1;
        @(posedge PCLK); #1;
        select(-1);
        penable = 1'b0;
        repeat (6) begin
            @(posedge PCLK); #1;
        end
        check("abort_no_pready_b", {63'd0, pready_b}, 64'd0);
        xfer(1, 0, 9'h044, 64'd0, 8'h0, 64'h01020304, 0, 3);
        idle(1);

        // Reset in the middle of a write's ACCESS phase drops the write.
        select(1);
        pwrite  = 1'b1;
        paddr   = 9'h040;
        pwdata  = 64'h0BADBEEF;
        pstrb   = 8'hF;
        penable = 1'b0;
        @(posedge PCLK); #1;
        penable = 1'b1;
        @(posedge PCLK); #1;
        PRESET = 1'b1;
        @(posedge PCLK); #1;
        PRESET = 1'b0;
        select(-1);
        penable = 1'b0;
        idle(5);
        check("reset_midaccess_pready_b", {63'd0, pready_b}, 64'd0);
        xfer(1, 0, 9'h040, 64'd0, 8'h0, 64'hCAFEF00D, 0, 3);

        // 64-bit instance: eight back-to-back writes then eight reads.
        for (int i = 0; i < 8; i++)
            xfer(2, 1, 9'(i * 8), c_data[i], 8'hFF, 64'd0, 0, 0);
        for (int i = 0; i < 8; i++)
            xfer(2, 0, 9'(i * 8), 64'd0, 8'h00, c_data[i], 0, 0);
        idle(4);

        check("scoreboard_drained", 64'(exp_q.size()), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not reach end of test");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/apb_sram_slave.md
# apb_sram_slave

Parametrised APB4 slave RAM, the next generation of the team's `apb_ram` bench target. It adds configurable data width, depth and wait states, byte-lane write strobes, and slave-error responses for misaligned or out-of-range accesses. It sits behind an APB master or interconnect as a memory-mapped scratch RAM. It also serves as a protocol-conformant DUT for the APB UVM environment.

## Interface

Parameters:
- `ADDR_WIDTH`, default 8: byte-address width of `paddr`.
- `DATA_WIDTH`, default 32: data width. Must be a multiple of 8 and at least 8. BYTES = DATA_WIDTH/8, AL = log2(BYTES).
- `DEPTH`, default 64: number of words. Must be ≤ 2^(ADDR_WIDTH−AL).
- `WAIT_STATES`, default 0: number of `pready`-low ACCESS cycles inserted per transfer. Range 0..255.

Ports:
- `PCLK` in 1: the single clock. All logic runs on the rising edge.
- `PRESET` in 1: reset, synchronous and active-high.
- `psel` in 1: slave select.
- `penable` in 1: access phase.
- `pwrite` in 1: 1 = write, 0 = read.
- `paddr` in ADDR_WIDTH: byte address.
- `pwdata` in DATA_WIDTH: write data.
- `pstrb` in BYTES: write byte-lane strobes.
- `prdata` out DATA_WIDTH: read data, valid while `pready`=1.
- `pready` out 1: transfer complete.
- `pslverr` out 1: error response, valid only while `pready`=1.

## Operation

- FSM has three states: IDLE, ACCESS, DONE.
- IDLE:
  - `psel`=1 and `penable`=0 at an edge: latch `paddr`, `pwrite`, `pwdata` and `pstrb`, compute the error flag, clear the wait counter, go to ACCESS.
  - `penable`=1 without a preceding setup is ignored; the FSM stays in IDLE.
- Error flag is set when either holds:
  - the low address bits are non-zero: `paddr`[AL−1:0] ≠ 0;
  - the word index is out of range: `paddr`[ADDR_WIDTH−1:AL] ≥ DEPTH.
- ACCESS, with the counter below WAIT_STATES: increment the counter. `pready` stays 0.
- ACCESS, with the counter equal to WAIT_STATES: `pready` is 1 for this cycle. At the edge that ends the cycle, with `psel` and `penable` high:
  - write without error: update only the byte lanes whose `pstrb` bit is 1. `pstrb`=0 is a legal no-op that returns OKAY.
  - read: `prdata` already holds the word.
  - error: no RAM update, `prdata`=0, `pslverr`=1.
  - then go to IDLE.
- DONE: a one-cycle internal marker, folded into IDLE. The next setup can be sampled on the edge immediately after completion.
- Abort: if `psel`=0 in ACCESS, go to IDLE with no write, and `pready`/`pslverr` deasserted next cycle.
- Inputs changing during ACCESS are ignored; the latched values are used.
- `pstrb` is ignored on reads.
- RAM contents are unaffected by reset and are undefined after power-up.

## Timing

- Reset values: `prdata`=0, `pready`=0, `pslverr`=0, FSM=IDLE, counter=0.
- Reset has priority over everything: asserting reset on a commit edge suppresses the write. A transfer in flight is dropped.
- All outputs are registered.
- `prdata`, `pready` and `pslverr` are loaded at the edge that makes the counter equal to WAIT_STATES. With WAIT_STATES=0, this is the setup-sampling edge itself.
- Transfer length is 2 + WAIT_STATES cycles, from setup through completion.
- `pready` is high for exactly one cycle per transfer and then returns to 0. `pslverr` and `prdata` return to 0 with it.
- Back-to-back transfers take 2 + WAIT_STATES cycles each, with no idle cycle required.
- Read-after-write to the same address, back-to-back, returns the new data.

## Test plan

Default parameters are used unless noted.

- **Reset.** Hold `PRESET`=1 for 2 cycles with `psel` toggling. Then `pready`=0, `pslverr`=0, `prdata`=0, and no write occurs.
- **Basic write/read.**
  - Write 0xDEADBEEF to address 0x10 with `pstrb`=0xF, then read 0x10.
  - `prdata`=0xDEADBEEF and `pslverr`=0.
  - Each transfer takes 2 cycles, and `pready` is high on the 2nd.
- **Byte strobes.**
  - Write 0x11223344 to 0x20 with `pstrb`=0xF.
  - Then write 0xAABBCCDD to 0x20 with `pstrb`=0x5.
  - A read of 0x20 returns 0x11BB33DD.
- **Errors.**
  - A write to 0x13 (misaligned) returns `pslverr`=1 and leaves the RAM unchanged.
  - A read of 0x100 with ADDR_WIDTH=9 (index 64 ≥ DEPTH) returns `pslverr`=1 and `prdata`=0.
- **Wait states.**
  - With WAIT_STATES=3, a read takes 5 cycles, `pready` is low for 3 ACCESS cycles, and then high for 1.
  - Dropping `psel` in the 2nd wait cycle aborts the transfer with no `pready`.
- **Back-to-back and width.**
  - With DATA_WIDTH=64, run 8 consecutive writes followed by 8 reads at addresses 0x00, 0x08, …, 0x38, with no idle cycles.
  - All read data matches.
  - Reset asserted mid-ACCESS of a write leaves the target word unchanged.
